stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes, a registered output stage and a selectable arbitration mode: fixed select or round-robin. It is the generalised successor of the team's fixed-width 4:1 combinational muxes. It sits between multiple producer streams and a single consumer in the datapath and sustains one beat per cycle under back-pressure.

## Interface
- WIDTH, 8, data width per channel
- NCH, 4, number of input channels (2..16, need not be a power of two)
- SELW, $clog2(NCH), width of channel index signals (derived, not overridden)

- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel valid
- in_ready  output  NCH  per-channel ready (combinational)
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel index used when mode=0
- out_data  output  WIDTH  registered data
- out_ch  output  SELW  registered index of the source channel of out_data
- out_valid  output  1  registered valid
- out_ready  input  1  consumer ready

## Operation
- Transfer on an input: in_valid[i] && in_ready[i] at a rising edge. Transfer on the output: out_valid && out_ready.
- load = ~out_valid || out_ready. The output register accepts a new beat whenever it is empty or being drained in the same cycle.
- Grant is a one-hot vector computed combinationally each cycle. At most one bit is set. in_ready[i] = grant[i] && load.
- Fixed mode (mode=0):
  - grant[sel] = in_valid[sel].
  - sel >= NCH gives no grant.
  - Other channels are never ready, even when valid.
- Round-robin mode (mode=1):
  - The search starts at the rr_ptr register and proceeds upward with wrap-around modulo NCH.
  - The first channel found with in_valid set is granted.
- rr_ptr behaviour:
  - rr_ptr resets to 0.
  - On every input transfer in round-robin mode, rr_ptr <= (granted index + 1) mod NCH. Wrap goes from NCH-1 to 0.
  - rr_ptr holds when there is no transfer and in fixed mode.
- Output register behaviour when load is true:
  - If a grant exists: out_data <= granted channel's data, out_ch <= granted index, out_valid <= 1.
  - With no grant: out_valid <= 0, and out_data/out_ch hold.
- When load is false (stalled), all output registers hold. out_data and out_ch must stay stable while out_valid && !out_ready.
- mode and sel are sampled every cycle with no pipelining. A change affects the grant in the same cycle, and a beat already in the output register is unaffected.
- Withdrawing in_valid without a transfer is permitted on the input side. The block itself never drops or duplicates a beat.

## Timing
- Reset (rst_n low, asynchronous assert, synchronous-to-clk deassert assumed from the reset tree):
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - in_ready is all zero while reset is asserted.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle when out_ready is held high.
- Paths from in_valid/mode/sel/out_ready to in_ready are combinational. There is no combinational path from in_data to out_data.
- Simultaneous drain and load: the old beat leaves and the new beat is captured in the same edge, so there is no bubble.
- Reset mid-stream: the beat held in the output register is discarded and rr_ptr returns to 0.

## Test plan
- Reset: assert rst_n=0 while out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately. After release, with all 4 channels valid in RR mode, the first granted channel is 0.
- Fixed mode, NCH=4, sel=2, all valid, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=8'hA5, out_ch=2. Streams one beat per cycle.
- Round-robin fairness, all 4 valid, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles. With only ch1 and ch3 valid -> 1,3,1,3.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1, out_data=8'h3C -> out_data/out_ch stable and in_ready all zero. out_ready=1 -> beat consumed and the next beat is loaded on the same edge.
- NCH=3, sel=3 (out of range), mode=0 -> in_ready=3'b000 and out_valid drains to 0. Round-robin at ch2 -> the next grant wraps to ch0.
- Mode switch: RR with rr_ptr=2, then mode=0, sel=0 for 2 beats, then mode=1 -> in fixed mode, rr_ptr holds at 2. After the switch back, the next RR grant is ch2 (if valid).

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with a registered output stage.
// Arbitration is either a fixed channel select or round-robin from rr_ptr.
module stream_mux_rr #(
    parameter int  WIDTH = 8,
    parameter int  NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH*WIDTH-1:0]  in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int              NPAD  = 2 ** SELW;
    localparam logic [SELW:0]   NCH_W = (SELW + 1)'(NCH);

    logic [NPAD-1:0]  vpad;
    logic             load;
    logic             found;
    logic [SELW-1:0]  gidx;
    logic [NCH-1:0]   grant;
    logic [WIDTH-1:0] gdata;
    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  rr_nxt;
    logic [SELW:0]    rr_inc;

    // Padding lets sel/pointer index safely when NCH is not a power of two.
    assign vpad = NPAD'(in_valid);

    // Reset gates load so no channel sees ready while rst_n is low.
    assign load = rst_n & (~out_valid | out_ready);

    always_comb begin : arb
        logic [SELW:0] idx;
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        if (mode) begin
            for (int k = 0; k < NCH; k++) begin
                idx = {1'b0, rr_ptr} + (SELW + 1)'(k);
                if (idx >= NCH_W)
                    idx = idx - NCH_W;
                if (!found && vpad[idx[SELW-1:0]]) begin
                    found = 1'b1;
                    gidx  = idx[SELW-1:0];
                end
            end
        end else if (({1'b0, sel} < NCH_W) && vpad[sel]) begin
            found = 1'b1;
            gidx  = sel;
        end
    end

    always_comb begin
        grant = '0;
        gdata = '0;
        for (int i = 0; i < NCH; i++) begin
            grant[i] = found && (gidx == SELW'(i));
            if (grant[i])
                gdata = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign in_ready = grant & {NCH{load}};

    assign rr_inc = {1'b0, gidx} + (SELW + 1)'(1);
    assign rr_nxt = (rr_inc == NCH_W) ? '0 : rr_inc[SELW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_data <= gdata;
                out_ch   <= gidx;
                if (mode)
                    rr_ptr <= rr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized and directed bench for stream_mux_rr: a 4-channel and a 3-channel
// instance run against a transaction-level reference model.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] d4 = '0;
    logic [3:0]  v4 = '0, r4;
    logic        md4 = 1'b0;
    logic [1:0]  s4 = '0;
    logic [7:0]  od4;
    logic [1:0]  oc4;
    logic        ov4;
    logic        ordy4 = 1'b1;

    logic [23:0] d3 = '0;
    logic [2:0]  v3 = '0, r3;
    logic        md3 = 1'b0;
    logic [1:0]  s3 = '0;
    logic [7:0]  od3;
    logic [1:0]  oc3;
    logic        ov3;
    logic        ordy3 = 1'b1;

    stream_mux_rr #(.WIDTH(8), .NCH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_ready(r4),
        .mode(md4), .sel(s4), .out_data(od4), .out_ch(oc4), .out_valid(ov4),
        .out_ready(ordy4));

    stream_mux_rr #(.WIDTH(8), .NCH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_ready(r3),
        .mode(md3), .sel(s3), .out_data(od3), .out_ch(oc3), .out_valid(ov3),
        .out_ready(ordy3));

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: pointer, and the beat held at the output.
    int         p4, mc4, p3, mc3;
    bit         mv4, mv3;
    logic [7:0] mdt4, mdt3;
    logic [3:0] a_rdy4, e_rdy4;
    logic [2:0] a_rdy3, e_rdy3;

    function automatic int ref_grant(int nch, bit md, int s, logic [15:0] v, int ptr);
        if (!md)
            return (s < nch && v[s]) ? s : -1;
        for (int k = 0; k < nch; k++)
            if (v[(ptr + k) % nch])
                return (ptr + k) % nch;
        return -1;
    endfunction

    task automatic clear_model();
        p4 = 0; mc4 = 0; mv4 = 0; mdt4 = '0;
        p3 = 0; mc3 = 0; mv3 = 0; mdt3 = '0;
    endtask

    // Samples in_ready late in the cycle, advances the model, then steps one edge.
    task automatic cycle();
        int g4, g3;
        bit ld4, ld3;
        #3;
        g4  = ref_grant(4, md4, int'(s4), {12'b0, v4}, p4);
        g3  = ref_grant(3, md3, int'(s3), {13'b0, v3}, p3);
        ld4 = !mv4 || ordy4;
        ld3 = !mv3 || ordy3;
        e_rdy4 = (ld4 && g4 >= 0) ? 4'(1 << g4) : 4'b0;
        e_rdy3 = (ld3 && g3 >= 0) ? 3'(1 << g3) : 3'b0;
        a_rdy4 = r4;
        a_rdy3 = r3;
        if (ld4) begin
            if (g4 >= 0) begin
                mv4 = 1; mdt4 = d4[g4*8 +: 8]; mc4 = g4;
                if (md4) p4 = (g4 + 1) % 4;
            end else mv4 = 0;
        end
        if (ld3) begin
            if (g3 >= 0) begin
                mv3 = 1; mdt3 = d3[g3*8 +: 8]; mc3 = g3;
                if (md3) p3 = (g3 + 1) % 3;
            end else mv3 = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_chk++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ov4); end
        n_chk++; if (od4 !== 8'h00 || oc4 !== 2'd0) begin n_fail++; $display("FAIL reset_data: got %h/%0d want 00/0", od4, oc4); end
        rst_n = 1'b1;
        clear_model();
        md4 = 0; s4 = 2; v4 = 4'hf; d4 = $urandom; ordy4 = 0;
        cycle();
        n_chk++; if (ov4 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", ov4); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (ov4 !== 1'b0 || od4 !== 8'h00 || oc4 !== 2'd0)
            begin n_fail++; $display("FAIL midreset_out: got %b/%h/%0d want 0/00/0", ov4, od4, oc4); end
        n_chk++; if (r4 !== 4'b0000) begin n_fail++; $display("FAIL midreset_ready: got %b want 0000", r4); end
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        md4 = 1; ordy4 = 1; d4 = $urandom;
        cycle();
        n_chk++; if (oc4 !== 2'd0 || ov4 !== 1'b1) begin n_fail++; $display("FAIL reset_first_rr: got ch %0d v %b want ch 0 v 1", oc4, ov4); end
    endtask

    task automatic test_fixed();
        do_reset();
        md4 = 0; s4 = 2; v4 = 4'hf; ordy4 = 1;
        d4 = $urandom; d4[23:16] = 8'hA5;
        cycle();
        n_chk++; if (a_rdy4 !== 4'b0100) begin n_fail++; $display("FAIL fixed_ready: got %b want 0100", a_rdy4); end
        n_chk++; if (od4 !== 8'hA5 || oc4 !== 2'd2) begin n_fail++; $display("FAIL fixed_beat: got %h/%0d want a5/2", od4, oc4); end
        for (int i = 0; i < 4; i++) begin
            d4 = $urandom;
            cycle();
            n_chk++; if (ov4 !== 1'b1 || od4 !== mdt4 || oc4 !== 2'd2)
                begin n_fail++; $display("FAIL fixed_stream%0d: got %b/%h/%0d want 1/%h/2", i, ov4, od4, oc4, mdt4); end
        end
    endtask

    task automatic test_rr();
        int seq1[6] = '{0, 1, 2, 3, 0, 1};
        int seq2[4] = '{1, 3, 1, 3};
        do_reset();
        md4 = 1; v4 = 4'hf; ordy4 = 1;
        for (int i = 0; i < 6; i++) begin
            d4 = $urandom;
            cycle();
            n_chk++; if (ov4 !== 1'b1 || oc4 !== 2'(seq1[i]) || od4 !== mdt4)
                begin n_fail++; $display("FAIL rr_all%0d: got %b/%0d/%h want 1/%0d/%h", i, ov4, oc4, od4, seq1[i], mdt4); end
        end
        do_reset();
        v4 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            d4 = $urandom;
            cycle();
            n_chk++; if (ov4 !== 1'b1 || oc4 !== 2'(seq2[i]) || od4 !== mdt4)
                begin n_fail++; $display("FAIL rr_sparse%0d: got %b/%0d/%h want 1/%0d/%h", i, ov4, oc4, od4, seq2[i], mdt4); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] nb;
        do_reset();
        md4 = 0; s4 = 1; v4 = 4'hf; ordy4 = 1;
        d4 = $urandom; d4[15:8] = 8'h3C;
        cycle();
        n_chk++; if (od4 !== 8'h3C || oc4 !== 2'd1) begin n_fail++; $display("FAIL bp_load: got %h/%0d want 3c/1", od4, oc4); end
        ordy4 = 0;
        for (int i = 0; i < 3; i++) begin
            d4 = $urandom; md4 = 1'($urandom);
            cycle();
            n_chk++; if (ov4 !== 1'b1 || od4 !== 8'h3C || oc4 !== 2'd1)
                begin n_fail++; $display("FAIL bp_hold%0d: got %b/%h/%0d want 1/3c/1", i, ov4, od4, oc4); end
            n_chk++; if (a_rdy4 !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 0000", i, a_rdy4); end
        end
        ordy4 = 1; md4 = 0; d4 = $urandom; nb = d4[15:8];
        cycle();
        n_chk++; if (ov4 !== 1'b1 || od4 !== nb || oc4 !== 2'd1)
            begin n_fail++; $display("FAIL bp_release: got %b/%h/%0d want 1/%h/1", ov4, od4, oc4, nb); end
    endtask

    task automatic test_mode_switch();
        int exp_ch[5] = '{0, 1, 0, 0, 2};
        do_reset();
        md4 = 1; v4 = 4'hf; ordy4 = 1; s4 = 0;
        for (int i = 0; i < 5; i++) begin
            md4 = (i == 2 || i == 3) ? 1'b0 : 1'b1;
            d4 = $urandom;
            cycle();
            n_chk++; if (oc4 !== 2'(exp_ch[i]) || od4 !== mdt4)
                begin n_fail++; $display("FAIL mode_switch%0d: got %0d/%h want %0d/%h", i, oc4, od4, exp_ch[i], mdt4); end
        end
    endtask

    task automatic test_nch3();
        do_reset();
        md3 = 0; s3 = 1; v3 = 3'b111; ordy3 = 1; d3 = $urandom;
        cycle();
        n_chk++; if (ov3 !== 1'b1 || oc3 !== 2'd1) begin n_fail++; $display("FAIL n3_fixed: got %b/%0d want 1/1", ov3, oc3); end
        s3 = 3;
        cycle();
        n_chk++; if (a_rdy3 !== 3'b000) begin n_fail++; $display("FAIL n3_oor_ready: got %b want 000", a_rdy3); end
        n_chk++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL n3_oor_drain: got %b want 0", ov3); end
        md3 = 1; v3 = 3'b100; d3 = $urandom;
        cycle();
        n_chk++; if (ov3 !== 1'b1 || oc3 !== 2'd2 || od3 !== mdt3)
            begin n_fail++; $display("FAIL n3_rr_top: got %b/%0d/%h want 1/2/%h", ov3, oc3, od3, mdt3); end
        v3 = 3'b111; d3 = $urandom;
        cycle();
        n_chk++; if (oc3 !== 2'd0 || od3 !== mdt3) begin n_fail++; $display("FAIL n3_rr_wrap: got %0d/%h want 0/%h", oc3, od3, mdt3); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            md4 = 1'($urandom); s4 = 2'($urandom); v4 = 4'($urandom); d4 = $urandom;
            ordy4 = ($urandom_range(0, 3) != 0);
            md3 = 1'($urandom); s3 = 2'($urandom); v3 = 3'($urandom); d3 = 24'($urandom);
            ordy3 = ($urandom_range(0, 3) != 0);
            cycle();
            n_chk++; if (a_rdy4 !== e_rdy4) begin n_fail++; $display("FAIL rnd4_ready@%0d: got %b want %b", i, a_rdy4, e_rdy4); end
            n_chk++; if (ov4 !== mv4 || od4 !== mdt4 || oc4 !== 2'(mc4))
                begin n_fail++; $display("FAIL rnd4_out@%0d: got %b/%h/%0d want %b/%h/%0d", i, ov4, od4, oc4, mv4, mdt4, mc4); end
            n_chk++; if (a_rdy3 !== e_rdy3) begin n_fail++; $display("FAIL rnd3_ready@%0d: got %b want %b", i, a_rdy3, e_rdy3); end
            n_chk++; if (ov3 !== mv3 || od3 !== mdt3 || oc3 !== 2'(mc3))
                begin n_fail++; $display("FAIL rnd3_out@%0d: got %b/%h/%0d want %b/%h/%0d", i, ov3, od3, oc3, mv3, mdt3, mc3); end
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_fixed();
        test_rr();
        test_back_to_back();
        test_mode_switch();
        test_nch3();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
